// File: rtl/seg7_capture_decoder.sv
// Snoops a multiplexed 7-segment bus, debounces each digit and rebuilds the
// displayed hex value, pulsing frame_valid once every digit has been captured.
module seg7_capture_decoder #(
    parameter int DIGITS = 4,
    parameter int STABLE = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [6:0]            seg_in,
    input  logic [DIGITS-1:0]     dig_sel,
    input  logic                  clear,
    output logic [4*DIGITS-1:0]   value,
    output logic [DIGITS-1:0]     digit_blank,
    output logic                  frame_valid,
    output logic                  pattern_err,
    output logic                  sel_err
);

    localparam int CNT_W  = $clog2(STABLE + 1);
    localparam int SAMP_W = DIGITS + 7;

    typedef enum logic {
        S_COLLECT,
        S_COMPLETE
    } state_t;

    // Returns {ok, blank, nibble}; blank segments decode as nibble 0.
    function automatic logic [5:0] decode_seg(input logic [6:0] seg);
        case (seg)
            7'h7E:   return 6'b10_0000;
            7'h30:   return 6'b10_0001;
            7'h6D:   return 6'b10_0010;
            7'h79:   return 6'b10_0011;
            7'h33:   return 6'b10_0100;
            7'h5B:   return 6'b10_0101;
            7'h5F:   return 6'b10_0110;
            7'h70:   return 6'b10_0111;
            7'h7F:   return 6'b10_1000;
            7'h7B:   return 6'b10_1001;
            7'h77:   return 6'b10_1010;
            7'h1F:   return 6'b10_1011;
            7'h4E:   return 6'b10_1100;
            7'h3D:   return 6'b10_1101;
            7'h4F:   return 6'b10_1110;
            7'h47:   return 6'b10_1111;
            7'h00:   return 6'b11_0000;
            default: return 6'b00_0000;
        endcase
    endfunction

    state_t                state;
    logic [SAMP_W-1:0]     samp_p0;
    logic [CNT_W-1:0]      cnt_p0;
    logic [DIGITS-1:0]     seen;
    logic [4*DIGITS-1:0]   shadow_val;
    logic [DIGITS-1:0]     shadow_blank;

    logic [SAMP_W-1:0]     cur;
    logic                  same;
    logic [CNT_W-1:0]      cnt_nxt;
    logic                  acc_vld;
    logic                  sel_onehot;
    logic                  sel_zero;
    logic [5:0]            dec;
    logic                  store;
    logic [DIGITS-1:0]     seen_nxt;
    logic [4*DIGITS-1:0]   shadow_val_nxt;
    logic [DIGITS-1:0]     shadow_blank_nxt;

    always_comb begin
        cur  = {dig_sel, seg_in};
        same = (cur == samp_p0);
        if (!same)
            cnt_nxt = CNT_W'(1);
        else if (cnt_p0 == CNT_W'(STABLE))
            cnt_nxt = cnt_p0;
        else
            cnt_nxt = cnt_p0 + CNT_W'(1);
        // A saturated counter seeing the same sample again must not re-accept.
        acc_vld = (cnt_nxt == CNT_W'(STABLE)) && (!same || cnt_p0 != CNT_W'(STABLE));

        sel_zero   = (dig_sel == '0);
        sel_onehot = !sel_zero && ((dig_sel & (dig_sel - DIGITS'(1))) == '0);
        dec        = decode_seg(seg_in);
        store      = acc_vld && sel_onehot && dec[5] && !clear;

        seen_nxt = ((state == S_COMPLETE) ? '0 : seen) | (store ? dig_sel : '0);

        shadow_val_nxt   = shadow_val;
        shadow_blank_nxt = shadow_blank;
        for (int i = 0; i < DIGITS; i++) begin
            if (store && dig_sel[i]) begin
                shadow_val_nxt[4*i +: 4] = dec[3:0];
                shadow_blank_nxt[i]      = dec[4];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_COLLECT;
            samp_p0      <= '0;
            cnt_p0       <= '0;
            seen         <= '0;
            shadow_val   <= '0;
            shadow_blank <= '0;
            value        <= '0;
            digit_blank  <= '0;
            frame_valid  <= 1'b0;
            pattern_err  <= 1'b0;
            sel_err      <= 1'b0;
        end else begin
            samp_p0     <= cur;
            frame_valid <= 1'b0;
            pattern_err <= acc_vld && !clear && sel_onehot && !dec[5];
            sel_err     <= acc_vld && !clear && !sel_zero && !sel_onehot;
            if (clear) begin
                state        <= S_COLLECT;
                cnt_p0       <= '0;
                seen         <= '0;
                shadow_val   <= '0;
                shadow_blank <= '0;
            end else begin
                cnt_p0       <= cnt_nxt;
                shadow_val   <= shadow_val_nxt;
                shadow_blank <= shadow_blank_nxt;
                seen         <= seen_nxt;
                // Publish the pre-update shadow; same-cycle captures seed the next frame.
                if (state == S_COMPLETE) begin
                    value       <= shadow_val;
                    digit_blank <= shadow_blank;
                    frame_valid <= 1'b1;
                end
                state <= (seen_nxt == '1) ? S_COMPLETE : S_COLLECT;
            end
        end
    end

endmodule
